// File: rtl/cpu_pkg.sv
// Shared datapath constants, ALU function codes and the ID/EX register layout.
// IDEX_BUBBLE is the all-zero no-op image loaded on reset, flush and load-use.
package cpu_pkg;

  localparam int CPU_DW = 32;
  localparam int CPU_RW = 5;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [CPU_RW-1:0] dest;
    logic [5:0]        alufun;
    logic [CPU_RW-1:0] rs_addr;
    logic [CPU_RW-1:0] rt_addr;
    logic [CPU_DW-1:0] rs_data;
    logic [CPU_DW-1:0] rt_data;
    logic [CPU_DW-1:0] imm;
    logic [4:0]        shamt;
    logic              alusrc1;
    logic              alusrc2;
`ifdef ALU_SHIFT_VAR_EN
    logic              shift_var;
`endif
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: EX/MEM beats MEM/WB beats register file; $0 never bypassed.
// Purely combinational, no flow control.
module fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_addr,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_dest,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] fwd_data
);

  logic nonzero;
  logic mem_hit;
  logic wb_hit;

  assign nonzero = (src_addr != '0);
  assign mem_hit = nonzero && mem_regwrite && (mem_dest == src_addr);
  assign wb_hit  = nonzero && wb_regwrite  && (wb_dest  == src_addr);

  always_comb begin
    fwd_data = reg_data;
    if (mem_hit)     fwd_data = mem_result;
    else if (wb_hit) fwd_data = wb_result;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register with bypassed ALU operands; 1-cycle latency, hold freezes fields, load-use stalls ID and injects a bubble.
// ALU_SHIFT_VAR_EN adds id_shift_var so sllv/srlv/srav take the shift amount from forwarded rs[4:0].
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW = CPU_DW,
  parameter int RW = CPU_RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic          id_alusrc1,
  input  logic          id_alusrc2,
`ifdef ALU_SHIFT_VAR_EN
  input  logic          id_shift_var,
`endif
  input  logic [5:0]    id_alufun,
  input  logic [RW-1:0] id_dest,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          hold,
  input  logic          flush,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_dest,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_result,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic [RW-1:0] ex_dest,
  output logic [5:0]    ex_alufun,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic          stall_req
);

  idex_t        r;
  idex_t        cap;
  logic         load_use;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  logic [4:0]   shift_amt;

  always_comb begin
    cap          = IDEX_BUBBLE;
    cap.valid    = id_valid;
    cap.regwrite = id_regwrite;
    cap.memread  = id_memread;
    cap.memwrite = id_memwrite;
    cap.dest     = id_dest;
    cap.alufun   = id_alufun;
    cap.rs_addr  = id_rs_addr;
    cap.rt_addr  = id_rt_addr;
    cap.rs_data  = id_rs_data;
    cap.rt_data  = id_rt_data;
    cap.imm      = id_imm;
    cap.shamt    = id_shamt;
    cap.alusrc1  = id_alusrc1;
    cap.alusrc2  = id_alusrc2;
`ifdef ALU_SHIFT_VAR_EN
    cap.shift_var = id_shift_var;
`endif
  end

  // A load in EX cannot bypass to the instruction now in ID: its data exists only after MEM.
  assign load_use = id_valid && r.valid && r.memread && (r.dest != '0) &&
                    (((r.dest == id_rs_addr) && id_uses_rs) ||
                     ((r.dest == id_rt_addr) && id_uses_rt));
  assign stall_req = load_use && !hold && !flush;

  always_ff @(posedge clk) begin
    if (reset)          r <= IDEX_BUBBLE;
    else if (flush)     r <= IDEX_BUBBLE;
    else if (hold)      r <= r;
    else if (stall_req) r <= IDEX_BUBBLE;
    else                r <= cap;
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_addr     (r.rs_addr),
    .reg_data     (r.rs_data),
    .mem_regwrite (mem_regwrite),
    .mem_dest     (mem_dest),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_dest      (wb_dest),
    .wb_result    (wb_result),
    .fwd_data     (rs_fwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_addr     (r.rt_addr),
    .reg_data     (r.rt_data),
    .mem_regwrite (mem_regwrite),
    .mem_dest     (mem_dest),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_dest      (wb_dest),
    .wb_result    (wb_result),
    .fwd_data     (rt_fwd)
  );

`ifdef ALU_SHIFT_VAR_EN
  assign shift_amt = r.shift_var ? rs_fwd[4:0] : r.shamt;
`else
  assign shift_amt = r.shamt;
`endif

  assign ex_a          = r.alusrc1 ? {{(DW-5){1'b0}}, shift_amt} : rs_fwd;
  assign ex_b          = r.alusrc2 ? r.imm : rt_fwd;
  assign ex_store_data = rt_fwd;

  assign ex_valid    = r.valid;
  assign ex_regwrite = r.regwrite;
  assign ex_memread  = r.memread;
  assign ex_memwrite = r.memwrite;
  assign ex_dest     = r.dest;
  assign ex_alufun   = r.alufun;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios then random traffic against a behavioural model.
// Works with or without ALU_SHIFT_VAR_EN defined.
module tb_alu_operand_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, id_valid, id_alusrc1, id_alusrc2;
  logic [4:0]  id_rs_addr, id_rt_addr, id_dest, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [5:0]  id_alufun;
  logic        id_regwrite, id_memread, id_memwrite, id_uses_rs, id_uses_rt;
  logic        hold, flush, mem_regwrite, wb_regwrite;
  logic [4:0]  mem_dest, wb_dest;
  logic [31:0] mem_result, wb_result;
`ifdef ALU_SHIFT_VAR_EN
  logic        id_shift_var;
`endif
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall_req;
  logic [4:0]  ex_dest;
  logic [5:0]  ex_alufun;
  logic [31:0] ex_a, ex_b, ex_store_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
`ifdef ALU_SHIFT_VAR_EN
    .id_shift_var(id_shift_var),
`endif
    .id_alufun(id_alufun), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .hold(hold), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_dest(wb_dest), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_dest(ex_dest), .ex_alufun(ex_alufun),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .stall_req(stall_req)
  );

  // Model of what the EX stage currently holds, in instruction terms.
  typedef struct {
    bit        valid, rw, mr, mw, s1, s2, sv;
    bit [4:0]  dest, rs, rt, sh;
    bit [5:0]  fun;
    bit [31:0] rsd, rtd, imm;
  } instr_t;

  instr_t m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] bypass(bit [4:0] a, bit [31:0] d);
    if (a != 0 && mem_regwrite && mem_dest == a) return mem_result;
    if (a != 0 && wb_regwrite && wb_dest == a) return wb_result;
    return d;
  endfunction

  function automatic bit model_stall();
    bit hit;
    hit = (m.dest == id_rs_addr && id_uses_rs) || (m.dest == id_rt_addr && id_uses_rt);
    return !hold && !flush && id_valid && m.valid && m.mr && m.dest != 0 && hit;
  endfunction

  task automatic check_all();
    bit [31:0] rs_v, rt_v, a_v;
    #1;
    rs_v = bypass(m.rs, m.rsd);
    rt_v = bypass(m.rt, m.rtd);
    if (!m.s1)      a_v = rs_v;
    else if (m.sv)  a_v = rs_v % 32;
    else            a_v = m.sh;
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_regwrite", ex_regwrite, m.rw);
    chk("ex_memread", ex_memread, m.mr);
    chk("ex_memwrite", ex_memwrite, m.mw);
    chk("ex_dest", ex_dest, m.dest);
    chk("ex_alufun", ex_alufun, m.fun);
    chk("ex_a", ex_a, a_v);
    chk("ex_b", ex_b, m.s2 ? m.imm : rt_v);
    chk("ex_store_data", ex_store_data, rt_v);
    chk("stall_req", stall_req, model_stall());
  endtask

  task automatic tick();
    instr_t n;
    instr_t z;
    z = '{default: 0};
    if (reset || flush)      n = z;
    else if (hold)           n = m;
    else if (model_stall())  n = z;
    else begin
      n = '{valid: id_valid, rw: id_regwrite, mr: id_memread, mw: id_memwrite,
            s1: id_alusrc1, s2: id_alusrc2, sv: 0, dest: id_dest, rs: id_rs_addr,
            rt: id_rt_addr, sh: id_shamt, fun: id_alufun, rsd: id_rs_data,
            rtd: id_rt_data, imm: id_imm};
`ifdef ALU_SHIFT_VAR_EN
      n.sv = id_shift_var;
`endif
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic idle();
    reset = 0; hold = 0; flush = 0;
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_alusrc1 = 0; id_alusrc2 = 0; id_alufun = 0;
    id_dest = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    mem_regwrite = 0; mem_dest = 0; mem_result = 0;
    wb_regwrite = 0; wb_dest = 0; wb_result = 0;
`ifdef ALU_SHIFT_VAR_EN
    id_shift_var = 0;
`endif
  endtask

  initial begin
    m = '{default: 0};
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check_all();
    chk("rst_a", ex_a, 0);
    chk("rst_stall", stall_req, 0);

    // Plain capture
    id_valid = 1; id_rs_addr = 1; id_rt_addr = 2; id_rs_data = 5; id_rt_data = 7;
    id_regwrite = 1; id_dest = 9; id_alufun = ALU_ADD;
    tick();
    idle();
    check_all();
    chk("cap_a", ex_a, 5);
    chk("cap_b", ex_b, 7);
    chk("cap_valid", ex_valid, 1);

    // Both bypass sources match rs
    id_valid = 1; id_rs_addr = 3; id_rs_data = 32'h11;
    tick();
    idle();
    mem_regwrite = 1; mem_dest = 3; mem_result = 32'hAA;
    wb_regwrite = 1;  wb_dest = 3;  wb_result = 32'hBB;
    check_all();
    chk("fwd_mem", ex_a, 32'hAA);
    mem_regwrite = 0;
    check_all();
    chk("fwd_wb", ex_a, 32'hBB);
    mem_regwrite = 1; mem_dest = 0; wb_dest = 0;
    check_all();
    chk("fwd_none", ex_a, 32'h11);

    // Shift amount paths
    idle();
    id_valid = 1; id_alusrc1 = 1; id_shamt = 31; id_alufun = ALU_SRA;
    id_rs_addr = 4; id_rs_data = 32'hFFFF_FFFF;
    tick();
    idle();
    check_all();
    chk("shamt", ex_a, 32'h1F);
`ifdef ALU_SHIFT_VAR_EN
    id_valid = 1; id_alusrc1 = 1; id_shift_var = 1; id_shamt = 31; id_rs_addr = 5;
    id_rs_data = 32'h1F; id_alufun = ALU_SRA;
    tick();
    idle();
    mem_regwrite = 1; mem_dest = 5; mem_result = 32'h23;
    check_all();
    chk("shift_var", ex_a, 3);
    idle();
`endif

    // Load-use on rt
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_dest = 8;
    tick();
    idle();
    id_valid = 1; id_rt_addr = 8; id_uses_rt = 1; id_rs_addr = 1; id_dest = 2; id_regwrite = 1;
    check_all();
    chk("lu_stall", stall_req, 1);
    tick();
    check_all();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_release", stall_req, 0);
    tick();
    check_all();
    chk("lu_capture", ex_valid, 1);

    // flush + hold together, with a pending load-use
    idle();
    id_valid = 1; id_memread = 1; id_dest = 8;
    tick();
    id_rs_addr = 8; id_uses_rs = 1; hold = 1; flush = 1;
    check_all();
    chk("fh_stall", stall_req, 0);
    tick();
    idle();
    check_all();
    chk("fh_bubble", ex_valid, 0);

    // hold freezes fields while the bypass keeps tracking mem_result
    id_valid = 1; id_rs_addr = 6; id_rs_data = 32'h66; id_dest = 10; id_regwrite = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      hold = 1;
      id_valid = 1; id_dest = 5'($urandom_range(11, 31)); id_rs_addr = 7;
      mem_regwrite = 1; mem_dest = 6; mem_result = $urandom;
      check_all();
      chk("hold_a", ex_a, mem_result);
      chk("hold_dest", ex_dest, 10);
      tick();
    end

    // Random traffic with small register range so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 15) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      id_valid = $urandom_range(0, 3) != 0;
      id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_dest = 5'($urandom_range(0, 3));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_alufun = 6'($urandom);
      id_alusrc1 = 1'($urandom); id_alusrc2 = 1'($urandom);
      id_regwrite = 1'($urandom); id_memread = 1'($urandom); id_memwrite = 1'($urandom);
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
`ifdef ALU_SHIFT_VAR_EN
      id_shift_var = 1'($urandom);
`endif
      mem_regwrite = 1'($urandom); mem_dest = 5'($urandom_range(0, 3)); mem_result = $urandom;
      wb_regwrite = 1'($urandom);  wb_dest = 5'($urandom_range(0, 3));  wb_result = $urandom;
      check_all();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
